pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
Program-counter stage for the single-cycle processor. It sits directly downstream of the next-PC mux21 bank: it registers the selected next address and presents the fetch address to instruction memory. It also feeds PC+STEP back to the mux "A" input. It handles reset boot, stall hold, halt/resume and misaligned-target traps.

Parameters:
WIDTH, 32, PC and address width in bits
STEP, 4, sequential increment in bytes
ALIGN_BITS, 2, low address bits that must be zero on a taken load
RESET_VECTOR, 32'h0000_0000, PC value after reset
TRAP_VECTOR, 32'h0000_0080, PC value loaded after a misalignment trap

Ports:
inClk  input  1  clock; all state updates on rising edge
inRst  input  1  synchronous reset, active-high
inNextPC  input  WIDTH  next address from the mux21 bank (branch/jump target path)
inLoad  input  1  1 = take inNextPC this cycle; 0 = sequential increment
inStall  input  1  hold PC this cycle
inHalt  input  1  enter HALTED
inResume  input  1  leave HALTED
outPC  output  WIDTH  current fetch address (registered)
outPCPlus  output  WIDTH  outPC+STEP, combinational; feeds mux inA
outValid  output  1  fetch address valid (RUN state only)
outHalted  output  1  high in HALTED
outTrap  output  1  high for the single TRAP cycle
outTrapAddr  output  WIDTH  offending target, registered on trap entry

Behaviour:
- One clock (inClk). Reset is synchronous, active-high (inRst), sampled on the rising edge and overriding all other inputs.
- Reset values: outPC=RESET_VECTOR, state=BOOT, outValid=0, outHalted=0, outTrap=0, outTrapAddr=0.
- States: BOOT, RUN, HALTED, TRAP. All outputs except outPCPlus are registered or decoded from state.
- BOOT: lasts exactly one cycle after inRst deasserts, then goes to RUN. PC stays at RESET_VECTOR, so the first valid fetch is RESET_VECTOR. All other inputs are ignored in BOOT.
- RUN uses priority inHalt > inStall > inLoad > increment:
  - inHalt=1: go to HALTED; PC holds. A coincident load is discarded.
  - inStall=1: PC holds; stay in RUN; outValid stays 1.
  - inLoad=1 with an aligned target (inNextPC[ALIGN_BITS-1:0]==0): PC<=inNextPC on the next edge (latency 1).
  - inLoad=1 with a misaligned target: go to TRAP; PC holds; outTrapAddr<=inNextPC.
  - Otherwise: PC<=PC+STEP, modulo 2^WIDTH. All-ones minus STEP-1 wraps to 0 with no flag.
- HALTED: PC holds; outValid=0; outHalted=1. inResume=1 returns to RUN next cycle with PC unchanged. inHalt, inStall and inLoad are ignored here. inResume is ignored in every other state.
- TRAP: one cycle with outTrap=1 and outValid=0. Next edge: PC<=TRAP_VECTOR and state goes to RUN. Inputs are ignored during TRAP. outTrapAddr holds until the next trap or reset.
- outPCPlus is always outPC+STEP, truncated to WIDTH, in every state including reset.
- Reset mid-operation, in any state and with any input, returns to the reset values on that edge.

Optional Feature:
Macro PC_UNIT_BRANCH_CNT_EN.
- Defined: adds output port outBranchCnt (32 bits).
  - Counts cycles in RUN where an aligned load is accepted (inLoad=1, inHalt=0, inStall=0).
  - Saturates at 32'hFFFF_FFFF.
  - Cleared by reset.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package pc_pkg holds:
  - the state encoding (BOOT=2'd0, RUN=2'd1, HALTED=2'd2, TRAP=2'd3);
  - default RESET_VECTOR and TRAP_VECTOR constants;
  - the STEP/ALIGN_BITS defaults.
- One sub-module, pc_incrementer: WIDTH-bit constant adder producing outPCPlus, reused for the next-state increment.

Test Plan:
- Reset release: inRst high 2 cycles then low, all other inputs 0 -> BOOT cycle with outPC=0 and outValid=0, then outPC=0, 4, 8, 12 with outValid=1.
- Branch and stall: at PC=0x10, inLoad=1, inNextPC=0x200 -> next outPC=0x200. Then inStall=1 with inLoad=1 for 2 cycles -> outPC stays 0x200. Then release -> 0x204.
- Misaligned target: inLoad=1, inNextPC=0x202 -> outTrap=1 for one cycle, outTrapAddr=0x202, outValid=0. Then outPC=0x80 in RUN.
- Halt/resume: inHalt=1 together with inLoad=1 to 0x400 -> HALTED with PC unchanged, load dropped. inResume=1 -> RUN, then PC+4.
- Wrap-around and reset mid-run: PC loaded to 0xFFFF_FFFC, then increment -> outPC=0, outPCPlus=4. Assert inRst while in HALTED -> outPC=RESET_VECTOR, BOOT, outHalted=0.
- With PC_UNIT_BRANCH_CNT_EN: 3 accepted loads, 1 stalled load, 1 misaligned load -> outBranchCnt=3.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared constants for the program-counter stage: FSM state encoding and
// default reset/trap vectors, sequential step and alignment width.
package pc_pkg;

  localparam logic [1:0] ST_BOOT   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;
  localparam logic [1:0] ST_TRAP   = 2'd3;

  localparam logic [31:0] PC_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] PC_TRAP_VECTOR  = 32'h0000_0080;
  localparam int          PC_STEP         = 4;
  localparam int          PC_ALIGN_BITS   = 2;

endpackage

// File: rtl/pc_incrementer.sv
// Constant adder producing PC+STEP; wraps modulo 2^WIDTH.
module pc_incrementer
  import pc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = PC_STEP
) (
  input  logic [WIDTH-1:0] inA,
  output logic [WIDTH-1:0] outSum
);

  assign outSum = inA + WIDTH'(STEP);

endmodule

// File: rtl/pc_unit.sv
// Program-counter stage: boot, run, stall, halt/resume and misaligned-target trap.
// Optional macro PC_UNIT_BRANCH_CNT_EN adds a saturating accepted-load counter port.
module pc_unit
  import pc_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter int               STEP         = PC_STEP,
  parameter int               ALIGN_BITS   = PC_ALIGN_BITS,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(PC_RESET_VECTOR),
  parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'(PC_TRAP_VECTOR)
) (
  input  logic             inClk,
  input  logic             inRst,
  input  logic [WIDTH-1:0] inNextPC,
  input  logic             inLoad,
  input  logic             inStall,
  input  logic             inHalt,
  input  logic             inResume,
  output logic [WIDTH-1:0] outPC,
  output logic [WIDTH-1:0] outPCPlus,
  output logic             outValid,
  output logic             outHalted,
  output logic             outTrap,
  output logic [WIDTH-1:0] outTrapAddr
`ifdef PC_UNIT_BRANCH_CNT_EN
  ,
  output logic [31:0]      outBranchCnt
`endif
);

  // Mask form keeps the check legal even when ALIGN_BITS is zero.
  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] trap_addr_q, trap_addr_d;
  logic [WIDTH-1:0] pc_plus;
  logic             target_aligned;
  logic             load_accept;

  pc_incrementer #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_inc (
    .inA    (pc_q),
    .outSum (pc_plus)
  );

  assign target_aligned = (inNextPC & ALIGN_MASK) == '0;
  assign load_accept    = (state_q == ST_RUN) && !inHalt && !inStall && inLoad
                          && target_aligned;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    trap_addr_d = trap_addr_q;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (inHalt) begin
          state_d = ST_HALTED;
        end else if (inStall) begin
          state_d = ST_RUN;
        end else if (inLoad) begin
          if (target_aligned) begin
            pc_d = inNextPC;
          end else begin
            state_d     = ST_TRAP;
            trap_addr_d = inNextPC;
          end
        end else begin
          pc_d = pc_plus;
        end
      end
      ST_HALTED: begin
        if (inResume) state_d = ST_RUN;
      end
      default: begin
        pc_d    = TRAP_VECTOR;
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge inClk) begin
    if (inRst) begin
      state_q     <= ST_BOOT;
      pc_q        <= RESET_VECTOR;
      trap_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      trap_addr_q <= trap_addr_d;
    end
  end

`ifdef PC_UNIT_BRANCH_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    if (en && (v != 32'hFFFF_FFFF)) return v + 32'd1;
    return v;
  endfunction

  logic [31:0] branch_cnt_q, branch_cnt_d;

  always_comb begin
    branch_cnt_d = sat_inc(branch_cnt_q, load_accept);
  end

  always_ff @(posedge inClk) begin
    if (inRst) branch_cnt_q <= '0;
    else       branch_cnt_q <= branch_cnt_d;
  end

  assign outBranchCnt = branch_cnt_q;
`else
  logic unused_load_accept;
  assign unused_load_accept = load_accept;
`endif

  assign outPC       = pc_q;
  assign outPCPlus   = pc_plus;
  assign outValid    = (state_q == ST_RUN);
  assign outHalted   = (state_q == ST_HALTED);
  assign outTrap     = (state_q == ST_TRAP);
  assign outTrapAddr = trap_addr_q;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios with literal expectations
// followed by randomized stimulus compared against a behavioural model.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] next_pc;
  logic        load, stall, halt, resume;
  logic [31:0] pc, pc_plus, trap_addr;
  logic        valid, halted, trap;
`ifdef PC_UNIT_BRANCH_CNT_EN
  logic [31:0] branch_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: mode flags plus PC, trap address and load count.
  bit          m_boot, m_halt, m_trap;
  logic [31:0] m_pc, m_taddr, m_cnt;

  always #5 clk = ~clk;

  pc_unit dut (
    .inClk       (clk),
    .inRst       (rst),
    .inNextPC    (next_pc),
    .inLoad      (load),
    .inStall     (stall),
    .inHalt      (halt),
    .inResume    (resume),
    .outPC       (pc),
    .outPCPlus   (pc_plus),
    .outValid    (valid),
    .outHalted   (halted),
    .outTrap     (trap),
    .outTrapAddr (trap_addr)
`ifdef PC_UNIT_BRANCH_CNT_EN
    ,
    .outBranchCnt(branch_cnt)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      m_pc = 32'h0; m_boot = 1; m_halt = 0; m_trap = 0; m_taddr = 0; m_cnt = 0;
    end else if (m_boot) begin
      m_boot = 0;
    end else if (m_trap) begin
      m_trap = 0; m_pc = 32'h80;
    end else if (m_halt) begin
      if (resume) m_halt = 0;
    end else if (halt) begin
      m_halt = 1;
    end else if (stall) begin
      // hold
    end else if (load) begin
      if (next_pc % 4 != 0) begin
        m_trap = 1; m_taddr = next_pc;
      end else begin
        m_pc = next_pc;
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      end
    end else begin
      m_pc = m_pc + 4;
    end
  endtask

  task automatic compare_all();
    chk("pc", pc, m_pc);
    chk("pc_plus", pc_plus, m_pc + 32'd4);
    chk("valid", {31'b0, valid}, {31'b0, !(m_boot || m_halt || m_trap)});
    chk("halted", {31'b0, halted}, {31'b0, m_halt});
    chk("trap", {31'b0, trap}, {31'b0, m_trap});
    chk("trap_addr", trap_addr, m_taddr);
`ifdef PC_UNIT_BRANCH_CNT_EN
    chk("branch_cnt", branch_cnt, m_cnt);
`endif
  endtask

  task automatic step(input bit r, input bit h, input bit s, input bit l, input bit rs,
                      input logic [31:0] nxt);
    rst = r; halt = h; stall = s; load = l; resume = rs; next_pc = nxt;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 32'h0);
  endtask

  initial begin
    rst = 1; halt = 0; stall = 0; load = 0; resume = 0; next_pc = 0;

    // Reset release and sequential fetch
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("reset_pc", pc, 32'h0);
    chk("reset_valid", {31'b0, valid}, 32'h0);
    chk("reset_taddr", trap_addr, 32'h0);
    chk("reset_pcplus", pc_plus, 32'h4);
    idle(); chk("first_fetch", pc, 32'h0); chk("first_valid", {31'b0, valid}, 32'h1);
    idle(); chk("seq_4", pc, 32'h4);
    idle(); chk("seq_8", pc, 32'h8);
    idle(); chk("seq_12", pc, 32'hC);
    idle(); chk("seq_16", pc, 32'h10);

    // Branch and stall
    step(0, 0, 0, 1, 0, 32'h200); chk("branch", pc, 32'h200);
    step(0, 0, 1, 1, 0, 32'h300); chk("stall1", pc, 32'h200);
    step(0, 0, 1, 1, 0, 32'h300); chk("stall2", pc, 32'h200);
    chk("stall_valid", {31'b0, valid}, 32'h1);
    idle(); chk("after_stall", pc, 32'h204);

    // Misaligned target
    step(0, 0, 0, 1, 0, 32'h202);
    chk("trap_flag", {31'b0, trap}, 32'h1);
    chk("trap_addr", trap_addr, 32'h202);
    chk("trap_valid", {31'b0, valid}, 32'h0);
    step(0, 1, 0, 1, 1, 32'h500);
    chk("trap_vec", pc, 32'h80);
    chk("trap_over", {31'b0, trap}, 32'h0);
    chk("trap_run", {31'b0, valid}, 32'h1);

    // Halt with coincident load, then resume
    step(0, 1, 0, 1, 0, 32'h400);
    chk("halt_pc", pc, 32'h80); chk("halted", {31'b0, halted}, 32'h1);
    step(0, 0, 0, 1, 0, 32'h600); chk("halt_hold", pc, 32'h80);
    step(0, 0, 0, 0, 1, 0); chk("resume_pc", pc, 32'h80);
    chk("resume_valid", {31'b0, valid}, 32'h1);
    idle(); chk("resume_inc", pc, 32'h84);

    // Wrap-around, then reset while halted
    step(0, 0, 0, 1, 0, 32'hFFFF_FFFC); chk("wrap_pre_plus", pc_plus, 32'h0);
    idle(); chk("wrap_pc", pc, 32'h0); chk("wrap_plus", pc_plus, 32'h4);
    step(0, 1, 0, 0, 0, 0); chk("halt2", {31'b0, halted}, 32'h1);
    step(1, 0, 0, 0, 1, 32'h123);
    chk("rst_pc", pc, 32'h0); chk("rst_halted", {31'b0, halted}, 32'h0);
    chk("rst_boot_valid", {31'b0, valid}, 32'h0);

    // Accepted-load counting: 3 accepted, 1 stalled, 1 misaligned
    idle();
    step(0, 0, 0, 1, 0, 32'h100);
    step(0, 0, 0, 1, 0, 32'h104);
    step(0, 0, 1, 1, 0, 32'h108);
    step(0, 0, 0, 1, 0, 32'h10A);
    idle();
    step(0, 0, 0, 1, 0, 32'h300);
    chk("cnt_pc", pc, 32'h300);
`ifdef PC_UNIT_BRANCH_CNT_EN
    chk("branch_cnt_3", branch_cnt, 32'd3);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] nxt;
      nxt = $urandom;
      if ($urandom_range(0, 1) == 0) nxt[1:0] = 2'b00;
      step($urandom_range(0, 63) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 2) == 0, nxt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
